rpn_stack: RTL and testbench
============================

RPN_STACK -- requirements
Module: rpn_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of 8-bit stack entries (power of two, 2..16).
REQ-002 SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port dIn  input  8  signed two's-complement operand for PUSH.
REQ-005 SHALL have port cmd  input  3  command code: 0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 SUB, 5 NEG, 6 DUP, 7 CLEAR.
REQ-006 SHALL have port cmdValid  input  1  single-cycle command strobe, driven from the debounced, edge-detected push buttons.
REQ-007 SHALL have port ready  output  1  high when a command can be accepted.
REQ-008 SHALL have port top  output  8  signed top-of-stack value, feeding the two's-complement display stage.
REQ-009 SHALL have port enableDisp  output  1  high when depth > 0; drives the display enable.
REQ-010 SHALL have port depth  output  5  current entry count, 0..DEPTH.
REQ-011 SHALL have port err  output  1  sticky stack-fault flag.
REQ-012 SHALL have port ovf  output  1  arithmetic-overflow flag for the last executed ADD, SUB or NEG.

Function
REQ-013 SHALL implement states IDLE, EXEC and FAULT.
REQ-014 In IDLE with ready=1, cmdValid=1 and a non-NOP cmd, the block SHALL latch cmd and, for PUSH, dIn, then enter EXEC.
REQ-015 EXEC SHALL last exactly one cycle with ready=0, commit the result, and return to IDLE. Results SHALL be visible on top and depth 2 edges after acceptance.
REQ-016 cmdValid SHALL be ignored while ready=0. NOP SHALL be ignored in every state.
REQ-017 PUSH SHALL write dIn above the current top, then increment depth.
REQ-018 POP SHALL decrement depth.
REQ-019 DUP SHALL copy the top entry, then increment depth.
REQ-020 ADD SHALL replace the top two entries (a below, b on top) with a+b and decrement depth. SUB SHALL do the same with a-b.
REQ-021 NEG SHALL replace the top entry with -top, with depth unchanged.
REQ-022 Arithmetic SHALL be 8-bit signed. ovf SHALL be set when the true result lies outside -128..127 (NEG of -128 included), and cleared by any other successful ADD, SUB or NEG.
REQ-023 PUSH or DUP with depth=DEPTH SHALL be an overflow fault.
REQ-024 POP, NEG or DUP with depth=0 SHALL be an underflow fault.
REQ-025 ADD or SUB with depth<2 SHALL be an underflow fault.
REQ-026 On any fault, stack contents and depth SHALL be unchanged, err SHALL be set to 1, and the state SHALL be FAULT.
REQ-027 In FAULT, ready SHALL be 1 and only CLEAR SHALL be accepted; all other commands SHALL be ignored.
REQ-028 CLEAR SHALL be accepted in IDLE or FAULT. It SHALL set depth=0, err=0 and ovf=0, then enter IDLE through EXEC.
REQ-029 top SHALL be 0 whenever depth=0, regardless of storage contents.
REQ-030 The depth counter SHALL never wrap; depth SHALL stay within 0..DEPTH.

Reset
REQ-031 Assertion of reset SHALL immediately force state=IDLE, depth=0, top=0, enableDisp=0, err=0, ovf=0 and ready=1, including in the middle of EXEC.
REQ-032 Storage RAM need not be reset. Its contents SHALL be unobservable until written.
REQ-033 The first command SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-034 When RPN_STACK_SATURATE_EN is defined, an overflowing ADD, SUB or NEG SHALL write 127 (positive overflow) or -128 (negative overflow), and ovf SHALL be set.
REQ-035 When RPN_STACK_SATURATE_EN is undefined, the result SHALL wrap modulo 256, and ovf SHALL be set.

Verification
REQ-036 PUSH 5, PUSH 3, SUB -> top=2, depth=1, ovf=0, enableDisp=1; each command has ready low for exactly one cycle.
REQ-037 PUSH 100, PUSH 100, ADD -> ovf=1; top=-56 without macro, top=127 with RPN_STACK_SATURATE_EN.
REQ-038 From reset, POP -> err=1, depth=0, top=0, ready=1. PUSH 7 is then ignored (depth=0). CLEAR -> err=0, state IDLE.
REQ-039 Nine PUSHes of 1..9 with DEPTH=8 -> depth=8, top=8, err=1 after the ninth. NEG is ignored until CLEAR.
REQ-040 PUSH -128, NEG -> ovf=1; top=-128 without macro, top=127 with macro. A second cmdValid pulse during EXEC is dropped (depth unchanged by it).
REQ-041 PUSH 4, then reset asserted mid-EXEC of a DUP -> depth=0, top=0, enableDisp=0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/rpn_stack_if.sv
// -----------------------------------------------------------------------------
// rpn_stack_if -- command/status bundle between the push-button front end and
// the RPN stack calculator core.
//
//   dIn        signed operand for PUSH
//   cmd        command code (0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 SUB, 5 NEG, 6 DUP,
//              7 CLEAR)
//   cmdValid   single-cycle command strobe
//   ready      core can accept a command this cycle
//   top        signed top-of-stack value (0 when the stack is empty)
//   enableDisp display enable, high while the stack holds entries
//   depth      current entry count
//   err        sticky stack-fault flag
//   ovf        overflow flag of the last executed ADD/SUB/NEG
//
// master: command source (front end / testbench); slave: the stack core.
// -----------------------------------------------------------------------------
interface rpn_stack_if;
    logic signed [7:0] dIn;
    logic [2:0]        cmd;
    logic              cmdValid;
    logic              ready;
    logic signed [7:0] top;
    logic              enableDisp;
    logic [4:0]        depth;
    logic              err;
    logic              ovf;

    modport master (
        output dIn, cmd, cmdValid,
        input  ready, top, enableDisp, depth, err, ovf
    );

    modport slave (
        input  dIn, cmd, cmdValid,
        output ready, top, enableDisp, depth, err, ovf
    );
endinterface

// File: rtl/rpn_stack.sv
// -----------------------------------------------------------------------------
// rpn_stack -- reverse-Polish-notation calculator stack with 8-bit signed
// entries.
//
// A command is accepted in IDLE (any non-NOP) or in FAULT (CLEAR only), is
// latched, and is executed in the single EXEC cycle that follows; the result
// appears on top/depth two rising edges after acceptance. Stack faults
// (overflow/underflow) leave contents untouched, raise the sticky err flag and
// park the FSM in FAULT until a CLEAR.
//
// Ports:
//   clock  system clock, rising-edge active
//   reset  asynchronous, active-high reset of all control state
//   bus    rpn_stack_if.slave: dIn, cmd, cmdValid in; ready, top, enableDisp,
//          depth, err, ovf out
//
// Parameter:
//   DEPTH  number of stack entries (power of two, 2..16)
//
// Build option:
//   RPN_STACK_SATURATE_EN  when defined, overflowing ADD/SUB/NEG results clamp
//                          to 127 / -128; otherwise they wrap modulo 256.
//                          ovf is set in both cases.
// -----------------------------------------------------------------------------
module rpn_stack #(
    parameter int DEPTH = 8
) (
    input logic        clock,
    input logic        reset,
    rpn_stack_if.slave bus
);

    localparam int         DATA_W = 8;
    localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULL   = 5'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        C_NOP   = 3'd0,
        C_PUSH  = 3'd1,
        C_POP   = 3'd2,
        C_ADD   = 3'd3,
        C_SUB   = 3'd4,
        C_NEG   = 3'd5,
        C_DUP   = 3'd6,
        C_CLEAR = 3'd7
    } cmd_t;

    // Overflow of a 9-bit exact result into the 8-bit entry: the two top bits
    // disagree exactly when the value lies outside -128..127.
    function automatic logic out_of_range(input logic signed [DATA_W:0] full);
        return full[DATA_W] != full[DATA_W-1];
    endfunction

    function automatic logic signed [DATA_W-1:0] fit8(input logic signed [DATA_W:0] full);
`ifdef RPN_STACK_SATURATE_EN
        if (out_of_range(full))
            return full[DATA_W] ? 8'sh80 : 8'sh7F;
        return full[DATA_W-1:0];
`else
        return full[DATA_W-1:0];
`endif
    endfunction

    state_t                    state, state_next;
    cmd_t                      cmd_q;
    logic signed [DATA_W-1:0]  din_q;
    logic [4:0]                depth_r, depth_next;
    logic                      err_r, err_next;
    logic                      ovf_r, ovf_next;
    logic                      accept;
    logic                      fault;

    // Storage is deliberately not reset; top is masked to 0 while empty, so
    // stale contents never reach the outputs.
    logic signed [DATA_W-1:0]  mem [DEPTH];
    logic                      wr_en;
    logic [AW-1:0]             wr_addr;
    logic signed [DATA_W-1:0]  wr_data;

    logic [AW-1:0]             addr_tos, addr_nos;
    logic signed [DATA_W-1:0]  tos, nos;
    logic signed [DATA_W:0]    wide;

    // DEPTH is a power of two, so the truncated addresses always stay in range;
    // when they would be meaningless (empty / single entry) the command faults
    // and nothing reads the value.
    assign addr_tos = AW'(depth_r - 5'd1);
    assign addr_nos = AW'(depth_r - 5'd2);
    assign tos      = mem[addr_tos];
    assign nos      = mem[addr_nos];

    // Acceptance: any real command in IDLE, only CLEAR while faulted.
    always_comb begin
        accept = 1'b0;
        if (bus.cmdValid) begin
            if (state == IDLE)
                accept = (bus.cmd != C_NOP);
            else if (state == FAULT)
                accept = (bus.cmd == C_CLEAR);
        end
    end

    // ---- stage p0: latch accepted command ----
    always_ff @(posedge clock) begin
        if (accept) begin
            cmd_q <= cmd_t'(bus.cmd);
            din_q <= bus.dIn;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // ---- stage p1: execute latched command ----
    always_comb begin
        state_next = state;
        depth_next = depth_r;
        err_next   = err_r;
        ovf_next   = ovf_r;
        wr_en      = 1'b0;
        wr_addr    = AW'(depth_r);
        wr_data    = din_q;
        wide       = '0;
        fault      = 1'b0;

        case (state)
            IDLE, FAULT: begin
                if (accept)
                    state_next = EXEC;
            end

            EXEC: begin
                state_next = IDLE;
                case (cmd_q)
                    C_PUSH: begin
                        if (depth_r == FULL) begin
                            fault = 1'b1;
                        end else begin
                            wr_en      = 1'b1;
                            wr_data    = din_q;
                            depth_next = depth_r + 5'd1;
                        end
                    end
                    C_POP: begin
                        if (depth_r == 5'd0)
                            fault = 1'b1;
                        else
                            depth_next = depth_r - 5'd1;
                    end
                    C_DUP: begin
                        if (depth_r == 5'd0 || depth_r == FULL) begin
                            fault = 1'b1;
                        end else begin
                            wr_en      = 1'b1;
                            wr_data    = tos;
                            depth_next = depth_r + 5'd1;
                        end
                    end
                    C_ADD, C_SUB: begin
                        if (depth_r < 5'd2) begin
                            fault = 1'b1;
                        end else begin
                            wide       = (cmd_q == C_ADD) ? (9'(nos) + 9'(tos))
                                                          : (9'(nos) - 9'(tos));
                            wr_en      = 1'b1;
                            wr_addr    = addr_nos;
                            wr_data    = fit8(wide);
                            ovf_next   = out_of_range(wide);
                            depth_next = depth_r - 5'd1;
                        end
                    end
                    C_NEG: begin
                        if (depth_r == 5'd0) begin
                            fault = 1'b1;
                        end else begin
                            wide     = 9'sd0 - 9'(tos);
                            wr_en    = 1'b1;
                            wr_addr  = addr_tos;
                            wr_data  = fit8(wide);
                            ovf_next = out_of_range(wide);
                        end
                    end
                    C_CLEAR: begin
                        depth_next = 5'd0;
                        err_next   = 1'b0;
                        ovf_next   = 1'b0;
                    end
                    default: ;
                endcase

                if (fault) begin
                    err_next   = 1'b1;
                    state_next = FAULT;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // ---- stage p2: commit ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            depth_r <= 5'd0;
            err_r   <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            depth_r <= depth_next;
            err_r   <= err_next;
            ovf_r   <= ovf_next;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign bus.ready      = (state != EXEC);
    assign bus.depth      = depth_r;
    assign bus.enableDisp = (depth_r != 5'd0);
    assign bus.top        = (depth_r == 5'd0) ? '0 : tos;
    assign bus.err        = err_r;
    assign bus.ovf        = ovf_r;

endmodule

// File: tb/tb_rpn_stack.sv
// -----------------------------------------------------------------------------
// tb_rpn_stack -- directed self-checking bench for rpn_stack (DEPTH = 8).
// Expected outputs are queued when a command is driven and popped/compared once
// the command has had time to complete. Define RPN_STACK_SATURATE_EN for both
// bench and RTL to exercise the saturating build.
// -----------------------------------------------------------------------------
module tb_rpn_stack;

    localparam logic [2:0] NOP   = 3'd0;
    localparam logic [2:0] PUSH  = 3'd1;
    localparam logic [2:0] POP   = 3'd2;
    localparam logic [2:0] ADD   = 3'd3;
    localparam logic [2:0] SUB   = 3'd4;
    localparam logic [2:0] NEG   = 3'd5;
    localparam logic [2:0] DUP   = 3'd6;
    localparam logic [2:0] CLEAR = 3'd7;

`ifdef RPN_STACK_SATURATE_EN
    localparam int ADD_OVF = 127;   // 100 + 100
    localparam int SUB_OVF = -128;  // -100 - 100
    localparam int NEG_OVF = 127;   // -(-128)
`else
    localparam int ADD_OVF = -56;   // 200 mod 256
    localparam int SUB_OVF = 56;    // -200 mod 256
    localparam int NEG_OVF = -128;  // 128 mod 256
`endif

    typedef struct packed {
        logic signed [7:0] top;
        logic [4:0]        depth;
        logic              err;
        logic              ovf;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    rpn_stack_if bus ();

    rpn_stack #(.DEPTH(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    function automatic exp_t mk(input int t, input int dp, input bit er, input bit ov);
        exp_t e;
        e.top   = 8'(t);
        e.depth = 5'(dp);
        e.err   = er;
        e.ovf   = ov;
        return e;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_outputs(input string tag, input exp_t e);
        check({tag, ".top"},   32'(bus.top),        32'(e.top));
        check({tag, ".depth"}, 32'(bus.depth),      32'(e.depth));
        check({tag, ".err"},   32'(bus.err),        32'(e.err));
        check({tag, ".ovf"},   32'(bus.ovf),        32'(e.ovf));
        check({tag, ".en"},    32'(bus.enableDisp), (e.depth != 5'd0) ? 1 : 0);
        check({tag, ".ready"}, 32'(bus.ready),      1);
    endtask

    task automatic pop_and_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            expect_outputs(tag, e);
        end
    endtask

    // Drive one command that must be accepted; ready must be low for exactly
    // the one EXEC cycle. With hold=1 the strobe stays high through EXEC and
    // must not be taken a second time.
    task automatic exec_cmd(input string tag, input logic [2:0] c,
                            input logic signed [7:0] d, input exp_t e, input bit hold);
        sb.push_back(e);
        @(negedge clock);
        bus.cmd      = c;
        bus.dIn      = d;
        bus.cmdValid = 1'b1;
        @(negedge clock);
        check({tag, ".busy"}, 32'(bus.ready), 0);
        if (!hold)
            bus.cmdValid = 1'b0;
        @(negedge clock);
        bus.cmdValid = 1'b0;
        if (hold) begin
            pop_and_compare(tag);
            @(negedge clock);
            expect_outputs({tag, ".nodup"}, e);
        end else begin
            pop_and_compare(tag);
        end
    endtask

    // Drive one command that must be ignored.
    task automatic ignore_cmd(input string tag, input logic [2:0] c,
                              input logic signed [7:0] d, input exp_t e);
        sb.push_back(e);
        @(negedge clock);
        bus.cmd      = c;
        bus.dIn      = d;
        bus.cmdValid = 1'b1;
        @(negedge clock);
        bus.cmdValid = 1'b0;
        check({tag, ".not_taken"}, 32'(bus.ready), 1);
        @(negedge clock);
        pop_and_compare(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd      = NOP;
        bus.dIn      = '0;
        bus.cmdValid = 1'b0;
        reset        = 1'b1;
        #12;
        expect_outputs("reset", mk(0, 0, 0, 0));
        @(negedge clock);
        reset = 1'b0;

        // Basic arithmetic.
        exec_cmd("push5", PUSH, 8'sd5, mk(5, 1, 0, 0), 1'b0);
        exec_cmd("push3", PUSH, 8'sd3, mk(3, 2, 0, 0), 1'b0);
        exec_cmd("sub",   SUB,  8'sd0, mk(2, 1, 0, 0), 1'b0);
        exec_cmd("clr1",  CLEAR, 8'sd0, mk(0, 0, 0, 0), 1'b0);

        // ADD overflow, then ovf cleared by a clean NEG; DUP and POP.
        exec_cmd("p100a",  PUSH, 8'sd100, mk(100, 1, 0, 0), 1'b0);
        exec_cmd("p100b",  PUSH, 8'sd100, mk(100, 2, 0, 0), 1'b0);
        exec_cmd("addovf", ADD,  8'sd0,   mk(ADD_OVF, 1, 0, 1), 1'b0);
        exec_cmd("negok",  NEG,  8'sd0,   mk(-ADD_OVF, 1, 0, 0), 1'b0);
        exec_cmd("dup",    DUP,  8'sd0,   mk(-ADD_OVF, 2, 0, 0), 1'b0);
        exec_cmd("pop",    POP,  8'sd0,   mk(-ADD_OVF, 1, 0, 0), 1'b0);
        ignore_cmd("nop",  NOP,  8'sd0,   mk(-ADD_OVF, 1, 0, 0));

        // SUB negative overflow.
        exec_cmd("pm100",  PUSH, -8'sd100, mk(-100, 2, 0, 0), 1'b0);
        exec_cmd("pp100",  PUSH, 8'sd100,  mk(100, 3, 0, 0), 1'b0);
        exec_cmd("subovf", SUB,  8'sd0,    mk(SUB_OVF, 2, 0, 1), 1'b0);
        exec_cmd("clr2",   CLEAR, 8'sd0,   mk(0, 0, 0, 0), 1'b0);

        // Underflow from empty, fault lock-out, CLEAR recovery.
        exec_cmd("popempty", POP,  8'sd0, mk(0, 0, 1, 0), 1'b0);
        ignore_cmd("push7",  PUSH, 8'sd7, mk(0, 0, 1, 0));
        exec_cmd("clr3",     CLEAR, 8'sd0, mk(0, 0, 0, 0), 1'b0);

        // Fill to capacity, then overflow.
        for (int i = 1; i <= 8; i++)
            exec_cmd($sformatf("fill%0d", i), PUSH, 8'(i), mk(i, i, 0, 0), 1'b0);
        exec_cmd("push9",   PUSH, 8'sd9, mk(8, 8, 1, 0), 1'b0);
        ignore_cmd("negf",  NEG,  8'sd0, mk(8, 8, 1, 0));
        exec_cmd("clr4",    CLEAR, 8'sd0, mk(0, 0, 0, 0), 1'b0);

        // NEG of -128 with the strobe held through EXEC.
        exec_cmd("pm128",  PUSH, -8'sd128, mk(-128, 1, 0, 0), 1'b0);
        exec_cmd("negovf", NEG,  8'sd0,    mk(NEG_OVF, 1, 0, 1), 1'b1);

        // ADD with one entry: underflow, ovf left as it was.
        exec_cmd("add1",  ADD,  8'sd0, mk(NEG_OVF, 1, 1, 1), 1'b0);
        exec_cmd("clr5",  CLEAR, 8'sd0, mk(0, 0, 0, 0), 1'b0);

        // Reset in the middle of a DUP's EXEC cycle.
        exec_cmd("push4", PUSH, 8'sd4, mk(4, 1, 0, 0), 1'b0);
        @(negedge clock);
        bus.cmd      = DUP;
        bus.cmdValid = 1'b1;
        @(negedge clock);
        check("dupx.busy", 32'(bus.ready), 0);
        bus.cmdValid = 1'b0;
        #1 reset = 1'b1;
        #1;
        expect_outputs("async_rst", mk(0, 0, 0, 0));
        #1 reset = 1'b0;

        // First command must be taken on the very first edge after reset.
        bus.cmd      = PUSH;
        bus.dIn      = 8'sd9;
        bus.cmdValid = 1'b1;
        sb.push_back(mk(9, 1, 0, 0));
        @(negedge clock);
        check("first_edge.busy", 32'(bus.ready), 0);
        bus.cmdValid = 1'b0;
        @(negedge clock);
        pop_and_compare("first_edge");

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
